// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch unit: datapath width, the
// NOP word presented when no instruction is held, the alignment mask for
// instruction addresses, and the fetch FSM state encoding.
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] INSTR_ALIGN_MASK = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    FAULT = 3'd4
  } fetch_state_e;

  // True when the low address bits make the address unusable as an
  // instruction address.
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return (addr_lo & INSTR_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// ---------------------------------------------------------------------------
// fetch_pc_reg
// Program counter register for the fetch unit. Each cycle the PC either
// loads the redirect target, advances by one word (wrapping modulo 2^32),
// or holds. The low two bits are forced to zero so the PC is always
// word-aligned, and the misalignment of the presented redirect target is
// flagged combinationally so the FSM can refuse it.
//
// Ports:
//   clk              clock
//   reset            asynchronous active-high reset (PC <= RESET_ADDR)
//   load_i           load redirect_addr_i into the PC
//   advance_i        PC <= PC + 4 (ignored when load_i is set)
//   redirect_addr_i  redirect target
//   pc_o             current PC
//   misaligned_o     redirect_addr_i is not word-aligned
// ---------------------------------------------------------------------------
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            advance_i,
  input  logic [XLEN-1:0] redirect_addr_i,
  output logic [XLEN-1:0] pc_o,
  output logic            misaligned_o
);

  logic [XLEN-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = {redirect_addr_i[XLEN-1:2], 2'b00};
    end else if (advance_i) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_ADDR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o         = pc_q;
  assign misaligned_o = is_misaligned(redirect_addr_i[1:0]);

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage: owns the PC, issues one word read at a time to instruction
// memory (valid/ready request, in-order response), holds the returned
// instruction for decode until it is consumed, and handles redirects from
// execute, discarding any fetch made stale by a redirect.
//
// Optional feature macro: FETCH_PERF_CNT_EN adds fetch_count / flush_count.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   imem_req_valid/ready/addr      fetch request channel
//   imem_resp_valid/data           in-order fetch response
//   instr_valid/ready              held-instruction handshake to decode
//   instr, instr_addr              held instruction (NOP when not valid)
//   redirect_valid, redirect_addr  PC change request from execute
//   misalign_fault                 a redirect target was not word-aligned
//   fetch_count, flush_count       (FETCH_PERF_CNT_EN only) event counters
// ---------------------------------------------------------------------------
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR  = fetch_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_addr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  output logic            misalign_fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] fetch_count,
  output logic [XLEN-1:0] flush_count
`endif
);

  fetch_state_e    state_q, state_d;
  logic            drop_q, drop_d;          // outstanding response must be discarded
  logic            instr_valid_q, instr_valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_addr_q, instr_addr_d;
  logic            fault_q, fault_d;

  logic [XLEN-1:0] pc;
  logic            pc_load, pc_advance, redir_misaligned;
  logic            req_fire, redir_ok, redir_bad;

  fetch_pc_reg #(
    .RESET_ADDR (RESET_ADDR)
  ) u_pc (
    .clk             (clk),
    .reset           (reset),
    .load_i          (pc_load),
    .advance_i       (pc_advance),
    .redirect_addr_i (redirect_addr),
    .pc_o            (pc),
    .misaligned_o    (redir_misaligned)
  );

  assign req_fire  = (state_q == REQ) && imem_req_ready;
  assign redir_ok  = redirect_valid && !redir_misaligned;
  assign redir_bad = redirect_valid && redir_misaligned;

  always_comb begin
    state_d       = state_q;
    drop_d        = drop_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_addr_d  = instr_addr_q;
    fault_d       = fault_q;
    pc_load       = 1'b0;
    pc_advance    = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redir_bad) begin
          fault_d = 1'b1;
          state_d = FAULT;
        end else if (redir_ok) begin
          pc_load = 1'b1;
        end
      end

      REQ: begin
        if (redir_bad) begin
          fault_d = 1'b1;
          state_d = FAULT;
          // A request accepted this cycle still has a response coming.
          if (req_fire) drop_d = 1'b1;
        end else if (redir_ok) begin
          pc_load = 1'b1;
          if (req_fire) begin
            drop_d  = 1'b1;
            state_d = WAIT;
          end
        end else if (req_fire) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (redirect_valid) begin
          // A response in the same cycle belongs to the old stream.
          drop_d = !imem_resp_valid;
          if (redir_bad) begin
            fault_d = 1'b1;
            state_d = FAULT;
          end else begin
            pc_load = 1'b1;
            if (imem_resp_valid) state_d = REQ;
          end
        end else if (imem_resp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            instr_d       = imem_resp_data;
            instr_addr_d  = pc;
            instr_valid_d = 1'b1;
            state_d       = HOLD;
          end
        end
      end

      HOLD: begin
        if (redir_bad) begin
          fault_d       = 1'b1;
          instr_valid_d = 1'b0;
          state_d       = FAULT;
        end else if (redir_ok) begin
          pc_load       = 1'b1;
          instr_valid_d = 1'b0;
          state_d       = REQ;
        end else if (instr_ready) begin
          pc_advance    = 1'b1;
          instr_valid_d = 1'b0;
          state_d       = REQ;
        end
      end

      FAULT: begin
        // Keep tracking a fetch that was in flight when the fault hit.
        if (drop_q && imem_resp_valid) drop_d = 1'b0;
        if (redir_ok) begin
          pc_load = 1'b1;
          fault_d = 1'b0;
          // If that fetch has not returned yet, wait for it (and drop it)
          // before issuing a new request so responses stay paired.
          state_d = (drop_q && !imem_resp_valid) ? WAIT : REQ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      drop_q        <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= NOP_INSTR;
      instr_addr_q  <= RESET_ADDR;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      drop_q        <= drop_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_addr_q  <= instr_addr_d;
      fault_q       <= fault_d;
    end
  end

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = pc;
  assign instr_valid    = instr_valid_q;
  assign instr          = instr_valid_q ? instr_q : NOP_INSTR;
  assign instr_addr     = instr_addr_q;
  assign misalign_fault = fault_q;

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] fetch_count_q, flush_count_q;
  logic            fetch_evt, flush_evt;

  assign fetch_evt = (state_q == HOLD) && instr_ready && !redirect_valid;
  // Only the first redirect against an in-flight fetch discards it.
  assign flush_evt = redirect_valid &&
                     (req_fire || ((state_q == WAIT) && !drop_q) || (state_q == HOLD));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      if (fetch_evt) fetch_count_q <= fetch_count_q + 32'd1;
      if (flush_evt) flush_count_q <= flush_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
  assign flush_count = flush_count_q;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule
